// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring 32-bit signed/unsigned divider, EX-stage responder.
// Latency: 33 cycles request-to-done (1 cycle for a zero divisor).
// Backpressure: requester holds div_start until div_done; dropping it mid-calc aborts.
module ex_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_data1,
  input  logic [31:0] div_data2,
  output logic        div_done,
  output logic [63:0] div_result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [32:0] rem;      // partial remainder, always < divisor
  logic [31:0] dvd;      // dividend bits shift out as quotient bits shift in
  logic [31:0] dvs;      // divisor magnitude
  logic        q_neg;
  logic        r_neg;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [33:0] shifted;
  logic [33:0] diff;
  logic        trial_neg;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes and one restoring iteration with final sign fixup
  always_comb begin
    abs1      = (div_signed && div_data1[31]) ? (~div_data1 + 32'd1) : div_data1;
    abs2      = (div_signed && div_data2[31]) ? (~div_data2 + 32'd1) : div_data2;
    shifted   = {rem, dvd[31]};
    diff      = shifted - {2'b00, dvs};
    trial_neg = diff[33];
    rem_next  = trial_neg ? shifted[32:0] : diff[32:0];
    quo_next  = {dvd[30:0], ~trial_neg};
    q_fix     = q_neg ? (~quo_next + 32'd1) : quo_next;
    r_fix     = r_neg ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
  end

  // Done is a pure function of state so reset clears it immediately
  always_comb begin
    div_done = (state == DONE);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      rem        <= 33'd0;
      dvd        <= 32'd0;
      dvs        <= 32'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_result <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            dvd   <= abs1;
            dvs   <= abs2;
            q_neg <= div_signed & (div_data1[31] ^ div_data2[31]);
            r_neg <= div_signed & div_data1[31];
            if (div_data2 == 32'd0) begin
              // Zero divisor: all-ones quotient, dividend passed through as remainder
              div_result <= {div_data1, 32'hFFFF_FFFF};
              state      <= DONE;
            end else begin
              cnt   <= 6'd0;
              rem   <= 33'd0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!div_start) begin
            // Requester flushed: abandon quietly, keep last result
            state <= IDLE;
          end else begin
            rem <= rem_next;
            dvd <= quo_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              div_result <= {r_fix, q_fix};
              state      <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_divider.md
# ex_divider

Iterative 32-bit integer divider that forms the responder (slave) end of the `ex_div` interface driven by the EX stage. It accepts a held `div_start` request with operands and a signedness flag. It computes the quotient and remainder with a radix-2 restoring algorithm, one quotient bit per cycle. It returns both results with a one-cycle `div_done` pulse, during which EX releases its pipeline stall.

## Interface
- No parameters; the data width is fixed at 32 bits.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `div_start`  in  1  — request. EX holds it high, with the operands stable, until `div_done` is seen. Low means no request or abort.
- `div_signed`  in  1  — 1: DIV.W/MOD.W (two's complement); 0: DIV.WU/MOD.WU.
- `div_data1`  in  32  — dividend.
- `div_data2`  in  32  — divisor.
- `div_done`  out  1  — result valid; high for exactly one cycle per completed operation.
- `div_result`  out  64  — [31:0] quotient, [63:32] remainder. Registered; holds its value until the next completion.

## Operation
- The state machine has three states: IDLE, CALC, DONE. It resets to IDLE, with `div_done`=0, `div_result`=0 and all internal registers 0.
- **IDLE:**
  - If `div_start`=1, latch the operands:
    - |dividend| and |divisor|; magnitudes are used only when `div_signed`=1.
    - quotient sign = sign1 XOR sign2, and remainder sign = sign1, both only when `div_signed`=1.
  - If the divisor is 0, go to DONE. Otherwise clear the 6-bit counter and the 33-bit partial remainder, then go to CALC.
- **CALC:**
  - Each cycle: shift {remainder, dividend} left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - The counter increments each cycle. After the 32nd iteration, apply the sign corrections, register `div_result`, and go to DONE.
  - If `div_start`=0 in any CALC cycle (EX flushed), abort: go to IDLE with no `div_done` and leave `div_result` unchanged.
- **DONE:**
  - `div_done`=1, driven combinationally from the state. Go to IDLE unconditionally.
  - `div_start` is ignored in this cycle. EX drops it combinationally when it sees `div_done`.
- **Sign rules:** the quotient truncates toward zero, and a nonzero remainder takes the sign of the dividend. Negation is two's complement, taken modulo 2^32.
- **Divide by zero:** quotient = 0xFFFFFFFF and remainder = dividend, for both signed and unsigned. These are written to `div_result` when the state moves from IDLE to DONE.
- **Signed overflow (0x80000000 / 0xFFFFFFFF):** quotient = 0x80000000, remainder = 0. This falls out of the modular arithmetic and needs no special case.
- **Operand changes:** changes on `div_data1`, `div_data2` or `div_signed` after the operands are latched are ignored.
- **Gap requirement:** EX must hold `div_start` low for at least one cycle between consecutive operations. The `div_done` cycle satisfies this for back-to-back divides.

## Timing
- Cycle 0 (`div_start` first high in IDLE): operands are latched at the end of the cycle.
- Cycles 1–32: CALC.
- Cycle 33: `div_done`=1 and `div_result` is valid. Normal latency is 33 cycles from the request to `div_done`.
- Divide by zero: `div_done` in cycle 1.
- Cycle 34: back in IDLE, and a new `div_start` is accepted in that cycle.
- Abort: if `div_start` is sampled low in CALC cycle k, the block is in IDLE at k+1 and can accept a new request at k+1.
- Reset during any state: the block goes immediately (asynchronously) to IDLE, with `div_done`=0 and `div_result`=0. No `div_done` pulse follows release of reset unless a new request is made.
- `div_done` is never high for two consecutive cycles.

## Test plan
- **Unsigned divide:** unsigned 100 / 7, start held → `div_done` exactly in cycle 33 with `div_result`={r=2, q=14}. `div_done` low in cycles 0–32 and again in cycle 34.
- **Signed divide:** signed 0xFFFFFFF9 / 2 (-7/2) → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- **Overflow and zero divisor:**
  - Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - Unsigned 0x80000000 / 0xFFFFFFFF → q=0, r=0x80000000.
  - 5 / 0 → `div_done` in cycle 1, q=0xFFFFFFFF, r=5.
- **Abort then restart:** drop `div_start` in cycle 10 → no `div_done`, `div_result` unchanged. Re-request 9/3 in cycle 11 → `div_done` in cycle 44 with q=3, r=0.
- **Back-to-back:** EX model drops start in the done cycle and re-raises it in the next → the second result arrives 34 cycles after the first. Operands are changed mid-CALC on the first op and must not affect its result.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously in cycle 20 → `div_done` and `div_result` go to 0 immediately. After release, no spurious `div_done` occurs while start is low.
